// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: checks each resolved branch/jump against the fetch
// prediction, raises a held redirect on mispredict and pulses flush.
// Keeps accepted-branch and mispredict counters.
// Optional: define BRU_BHT_EN to build a 2-bit saturating branch history
// table that fetch queries through pred_pc/pred_taken.
module branch_resolve_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic            br_taken,
    input  logic            br_is_jump,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_target,
    input  logic            br_pred_taken,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    output logic            flush,
    output logic            misalign,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken
);

    typedef enum logic [0:0] {StIdle, StRedirect} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic            flush_q, flush_d;
    logic            misalign_q, misalign_d;
    logic [31:0]     branch_count_q, branch_count_d;
    logic [31:0]     mispredict_count_q, mispredict_count_d;

    logic            accept;
    logic            actual;
    logic            mispredict;
    logic            misaligned;
    logic [XLEN-1:0] correct_pc;

    // Only some lookup PC bits index the table; fold the rest away.
    logic            unused_pred_pc;
    assign unused_pred_pc = ^pred_pc;

    // Decode of the branch currently presented
    always_comb begin
        accept     = br_valid && br_ready;
        actual     = br_is_jump | br_taken;
        mispredict = actual != br_pred_taken;
        misaligned = actual && (br_target[1:0] != 2'b00);
        correct_pc = actual ? br_target : br_pc + XLEN'(4);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FSM next state: misaligned targets never redirect
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (accept && !misaligned && mispredict) state_d = StRedirect;
            StRedirect: if (redir_ready) state_d = StIdle;
        endcase
    end

    // FSM outputs: redirect request comes straight from the state flop
    always_comb begin
        br_ready    = (state_q == StIdle);
        redir_valid = (state_q == StRedirect);
    end

    // Datapath next state: pulses, redirect PC and statistics
    always_comb begin
        redir_pc_d         = redir_pc_q;
        flush_d            = 1'b0;
        misalign_d         = 1'b0;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (accept) begin
            branch_count_d = branch_count_q + 32'd1;
            if (misaligned) begin
                misalign_d = 1'b1;
                flush_d    = 1'b1;
            end else if (mispredict) begin
                redir_pc_d         = correct_pc;
                flush_d            = 1'b1;
                mispredict_count_d = mispredict_count_q + 32'd1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redir_pc_q         <= '0;
            flush_q            <= 1'b0;
            misalign_q         <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            redir_pc_q         <= redir_pc_d;
            flush_q            <= flush_d;
            misalign_q         <= misalign_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign redir_pc         = redir_pc_q;
    assign flush            = flush_q;
    assign misalign         = misalign_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

`ifdef BRU_BHT_EN
    localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

    logic [1:0]      bht_q [BHT_ENTRIES];
    logic [1:0]      bht_d [BHT_ENTRIES];
    logic [IdxW-1:0] upd_idx;
    logic [IdxW-1:0] look_idx;

    // Saturating counter update for accepted conditional branches only
    always_comb begin
        upd_idx  = br_pc[IdxW+1:2];
        look_idx = pred_pc[IdxW+1:2];
        bht_d    = bht_q;
        if (accept && !br_is_jump) begin
            if (br_taken) begin
                if (bht_q[upd_idx] != 2'b11) bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
            end else begin
                if (bht_q[upd_idx] != 2'b00) bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
            end
        end
    end

    // Table storage; entries start weakly not-taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= 2'b01;
        end else begin
            bht_q <= bht_d;
        end
    end

    // Lookup reads the registered table, so a same-cycle write is not visible
    assign pred_taken = bht_q[look_idx][1];
`else
    logic [31:0] unused_bht_cfg;
    assign unused_bht_cfg = BHT_ENTRIES;
    assign pred_taken     = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
// Covers BHT behaviour as well when compiled with BRU_BHT_EN.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_valid;
    logic        br_ready;
    logic        br_taken;
    logic        br_is_jump;
    logic [31:0] br_pc;
    logic [31:0] br_target;
    logic        br_pred_taken;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic        flush;
    logic        misalign;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
    logic [31:0] pred_pc;
    logic        pred_taken;

    int n_checks = 0;
    int n_fail   = 0;

    branch_resolve_unit #(
        .XLEN        (32),
        .BHT_ENTRIES (64)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .br_valid         (br_valid),
        .br_ready         (br_ready),
        .br_taken         (br_taken),
        .br_is_jump       (br_is_jump),
        .br_pc            (br_pc),
        .br_target        (br_target),
        .br_pred_taken    (br_pred_taken),
        .redir_valid      (redir_valid),
        .redir_ready      (redir_ready),
        .redir_pc         (redir_pc),
        .flush            (flush),
        .misalign         (misalign),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count),
        .pred_pc          (pred_pc),
        .pred_taken       (pred_taken)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic tk, input logic jmp, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic pred);
        br_valid      = v;
        br_taken      = tk;
        br_is_jump    = jmp;
        br_pc         = pc;
        br_target     = tgt;
        br_pred_taken = pred;
    endtask

    initial begin
        rst_n       = 1'b0;
        redir_ready = 1'b0;
        pred_pc     = 32'h40;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();

        // Reset state
        check("rst_redir_valid", {31'b0, redir_valid}, 32'd0);
        check("rst_redir_pc", redir_pc, 32'h0);
        check("rst_flush", {31'b0, flush}, 32'd0);
        check("rst_misalign", {31'b0, misalign}, 32'd0);
        check("rst_branch_count", branch_count, 32'd0);
        check("rst_mispredict_count", mispredict_count, 32'd0);
        check("rst_br_ready", {31'b0, br_ready}, 32'd1);
        check("rst_pred_taken", {31'b0, pred_taken}, 32'd0);

        // Correct not-taken prediction
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h100, 32'h200, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("nt_ok_redir_valid", {31'b0, redir_valid}, 32'd0);
        check("nt_ok_flush", {31'b0, flush}, 32'd0);
        check("nt_ok_branch_count", branch_count, 32'd1);
        check("nt_ok_mispredict_count", mispredict_count, 32'd0);

        // Taken mispredict, fetch stalls; a new branch waits in the meantime
        drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h200, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h500, 32'h600, 1'b0);
        check("tk_mp_redir_valid_c1", {31'b0, redir_valid}, 32'd1);
        check("tk_mp_redir_pc_c1", redir_pc, 32'h200);
        check("tk_mp_flush_c1", {31'b0, flush}, 32'd1);
        check("tk_mp_br_ready_c1", {31'b0, br_ready}, 32'd0);
        check("tk_mp_mispredict_count", mispredict_count, 32'd1);
        tick();
        check("tk_mp_redir_valid_c2", {31'b0, redir_valid}, 32'd1);
        check("tk_mp_redir_pc_c2", redir_pc, 32'h200);
        check("tk_mp_flush_c2", {31'b0, flush}, 32'd0);
        check("tk_mp_br_ready_c2", {31'b0, br_ready}, 32'd0);
        tick();
        check("tk_mp_redir_valid_c3", {31'b0, redir_valid}, 32'd1);
        check("tk_mp_redir_pc_c3", redir_pc, 32'h200);
        check("tk_mp_branch_count_held", branch_count, 32'd2);
        redir_ready = 1'b1;
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("tk_mp_done_redir_valid", {31'b0, redir_valid}, 32'd0);
        check("tk_mp_done_br_ready", {31'b0, br_ready}, 32'd1);
        check("tk_mp_done_branch_count", branch_count, 32'd2);
        check("tk_mp_done_mispredict_count", mispredict_count, 32'd1);

        // Not-taken mispredict: fall-through PC, fetch ready at once
        drive(1'b1, 1'b0, 1'b0, 32'h3FC, 32'h500, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("nt_mp_redir_valid", {31'b0, redir_valid}, 32'd1);
        check("nt_mp_redir_pc", redir_pc, 32'h400);
        check("nt_mp_flush", {31'b0, flush}, 32'd1);
        check("nt_mp_mispredict_count", mispredict_count, 32'd2);
        tick();
        check("nt_mp_done_redir_valid", {31'b0, redir_valid}, 32'd0);
        check("nt_mp_done_flush", {31'b0, flush}, 32'd0);
        check("nt_mp_branch_count", branch_count, 32'd3);

        // Jump predicted taken: no redirect despite br_taken=0
        drive(1'b1, 1'b0, 1'b1, 32'h10, 32'h80, 1'b1);
        tick();
        check("jmp_ok_redir_valid", {31'b0, redir_valid}, 32'd0);
        check("jmp_ok_flush", {31'b0, flush}, 32'd0);
        check("jmp_ok_branch_count", branch_count, 32'd4);

        // Jump predicted not-taken: redirect to target
        drive(1'b1, 1'b0, 1'b1, 32'h10, 32'h80, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("jmp_mp_redir_valid", {31'b0, redir_valid}, 32'd1);
        check("jmp_mp_redir_pc", redir_pc, 32'h80);
        check("jmp_mp_mispredict_count", mispredict_count, 32'd3);
        tick();
        check("jmp_mp_done_redir_valid", {31'b0, redir_valid}, 32'd0);

        // Misaligned taken target: flush + misalign pulse, no redirect
        drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h202, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("mis_misalign", {31'b0, misalign}, 32'd1);
        check("mis_flush", {31'b0, flush}, 32'd1);
        check("mis_redir_valid", {31'b0, redir_valid}, 32'd0);
        check("mis_redir_pc_kept", redir_pc, 32'h80);
        check("mis_mispredict_count", mispredict_count, 32'd3);
        check("mis_branch_count", branch_count, 32'd6);
        tick();
        check("mis_misalign_pulse", {31'b0, misalign}, 32'd0);
        check("mis_flush_pulse", {31'b0, flush}, 32'd0);

        // Fall-through PC wraps modulo 2^32
        drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("wrap_redir_pc", redir_pc, 32'h3);
        check("wrap_mispredict_count", mispredict_count, 32'd4);
        tick();

        // Reset while a redirect is pending
        redir_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h300, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("pre_rst_redir_valid", {31'b0, redir_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_redir_valid", {31'b0, redir_valid}, 32'd0);
        check("mid_rst_redir_pc", redir_pc, 32'h0);
        check("mid_rst_flush", {31'b0, flush}, 32'd0);
        check("mid_rst_br_ready", {31'b0, br_ready}, 32'd1);
        check("mid_rst_branch_count", branch_count, 32'd0);
        check("mid_rst_mispredict_count", mispredict_count, 32'd0);
        rst_n       = 1'b1;
        redir_ready = 1'b1;
        pred_pc     = 32'h40;

`ifdef BRU_BHT_EN
        // 01 -> 10 -> 11 -> 11 with taken branches (predicted taken, so no redirect)
        check("bht_init", {31'b0, pred_taken}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h44, 1'b1);
        check("bht_pre_update", {31'b0, pred_taken}, 32'd0);
        tick();
        check("bht_t1", {31'b0, pred_taken}, 32'd1);
        tick();
        check("bht_t2", {31'b0, pred_taken}, 32'd1);
        tick();
        check("bht_t3", {31'b0, pred_taken}, 32'd1);
        // Not-taken: 11 -> 10 -> 01 -> 00 -> 00
        drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h44, 1'b0);
        tick();
        check("bht_n1", {31'b0, pred_taken}, 32'd1);
        tick();
        check("bht_n2", {31'b0, pred_taken}, 32'd0);
        tick();
        tick();
        check("bht_n4", {31'b0, pred_taken}, 32'd0);
        // Jumps leave the table alone
        drive(1'b1, 1'b1, 1'b1, 32'h40, 32'h80, 1'b1);
        tick();
        tick();
        check("bht_jump_no_update", {31'b0, pred_taken}, 32'd0);
        // 0x140 aliases 0x40 with 64 entries: 00 -> 01 -> 10
        drive(1'b1, 1'b1, 1'b0, 32'h140, 32'h144, 1'b1);
        tick();
        check("bht_alias_1", {31'b0, pred_taken}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("bht_alias_2", {31'b0, pred_taken}, 32'd1);
        pred_pc = 32'h140;
        #1;
        check("bht_alias_lookup", {31'b0, pred_taken}, 32'd1);
        check("bht_branch_count", branch_count, 32'd11);
`else
        // No table: static not-taken regardless of history
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h44, 1'b1);
        tick();
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("static_pred_taken", {31'b0, pred_taken}, 32'd0);
        check("static_branch_count", branch_count, 32'd3);
        check("static_no_redirect", {31'b0, redir_valid}, 32'd0);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
